// File: rtl/epc_stack.sv
// Exception-PC stack: saves faulting PCs on exception, unwinds on ERET, allows MTC0 writes
// to the current entry, and flags overflow/underflow of the nesting depth.
module epc_stack #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         exc_valid,
    input  logic [WIDTH-1:0]             exc_pc,
    input  logic                         exc_in_ds,
    input  logic                         eret,
    input  logic                         mtc0_we,
    input  logic [WIDTH-1:0]             mtc0_data,
    input  logic                         clr_flags,
    output logic [WIDTH-1:0]             epc,
    output logic                         bd,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         exl,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);

    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [WIDTH-1:0] entry_d [DEPTH];
    logic [DEPTH-1:0] bd_q, bd_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             empty, full;
    logic [IW-1:0]    top_idx;
    logic [WIDTH-1:0] cap_pc;

    always_comb begin
        empty   = (level_q == '0);
        full    = (level_q == LW'(DEPTH));
        top_idx = empty ? '0 : IW'(level_q - LW'(1));
        // A delay-slot fault must resume at the branch, one word earlier.
        cap_pc  = exc_in_ds ? (exc_pc - WIDTH'(4)) : exc_pc;
    end

    always_comb begin
        entry_d = entry_q;
        bd_d    = bd_q;
        level_d = level_q;
        ovf_d   = ovf_q & ~clr_flags;
        unf_d   = unf_q & ~clr_flags;
        if (exc_valid) begin
            if (eret && !empty) begin
                entry_d[top_idx] = cap_pc;
                bd_d[top_idx]    = exc_in_ds;
            end else if (full) begin
                entry_d[IW'(DEPTH - 1)] = cap_pc;
                bd_d[IW'(DEPTH - 1)]    = exc_in_ds;
                ovf_d                   = 1'b1;
            end else begin
                entry_d[IW'(level_q)] = cap_pc;
                bd_d[IW'(level_q)]    = exc_in_ds;
                level_d               = level_q + LW'(1);
            end
        end else if (eret) begin
            if (!empty) begin
                level_d = level_q - LW'(1);
            end else begin
                unf_d = 1'b1;
            end
        end else if (mtc0_we) begin
            entry_d[top_idx] = mtc0_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= RESET_VAL;
            end
            bd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            entry_q <= entry_d;
            bd_q    <= bd_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign epc       = entry_q[top_idx];
    assign bd        = bd_q[top_idx];
    assign level     = level_q;
    assign exl       = !empty;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_epc_stack.sv
// Bench for epc_stack: directed nesting/boundary sequences plus random traffic, all checked
// every cycle against a stack model, with literal expectations pinning key points.
module tb_epc_stack;

    logic        clk;
    logic        rst_n;
    logic        exc_valid, exc_in_ds, eret, mtc0_we, clr_flags;
    logic [31:0] exc_pc, mtc0_data;
    logic [31:0] epc;
    logic        bd, exl, overflow, underflow;
    logic [2:0]  level;
    logic [15:0] epc16;
    logic        bd16, exl16, ovf16, unf16;
    logic [2:0]  level16;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: array of saved PCs plus an integer depth.
    logic [31:0] m_pc [4];
    logic        m_bd [4];
    int          m_lvl;
    logic        m_ovf, m_unf;

    epc_stack #(.WIDTH(32), .DEPTH(4), .RESET_VAL(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .exc_valid(exc_valid), .exc_pc(exc_pc),
        .exc_in_ds(exc_in_ds), .eret(eret), .mtc0_we(mtc0_we), .mtc0_data(mtc0_data),
        .clr_flags(clr_flags), .epc(epc), .bd(bd), .level(level), .exl(exl),
        .overflow(overflow), .underflow(underflow)
    );

    epc_stack #(.WIDTH(16), .DEPTH(4), .RESET_VAL(16'h0)) dut16 (
        .clk(clk), .rst_n(rst_n), .exc_valid(exc_valid), .exc_pc(exc_pc[15:0]),
        .exc_in_ds(exc_in_ds), .eret(eret), .mtc0_we(mtc0_we), .mtc0_data(mtc0_data[15:0]),
        .clr_flags(clr_flags), .epc(epc16), .bd(bd16), .level(level16), .exl(exl16),
        .overflow(ovf16), .underflow(unf16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pc[i] = 32'h0;
            m_bd[i] = 1'b0;
        end
        m_lvl = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] cap;
        int          top;
        cap = exc_in_ds ? exc_pc - 32'd4 : exc_pc;
        top = (m_lvl == 0) ? 0 : m_lvl - 1;
        if (clr_flags) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (exc_valid) begin
            if (eret && m_lvl > 0) begin
                m_pc[m_lvl-1] = cap;
                m_bd[m_lvl-1] = exc_in_ds;
            end else if (m_lvl == 4) begin
                m_pc[3] = cap;
                m_bd[3] = exc_in_ds;
                m_ovf   = 1'b1;
            end else begin
                m_pc[m_lvl] = cap;
                m_bd[m_lvl] = exc_in_ds;
                m_lvl++;
            end
        end else if (eret) begin
            if (m_lvl > 0) m_lvl--;
            else m_unf = 1'b1;
        end else if (mtc0_we) begin
            m_pc[top] = mtc0_data;
        end
    endtask

    // Single owner of the model; compares every cycle just after the edge.
    always @(posedge clk or negedge rst_n) begin
        int top;
        if (!rst_n) model_reset();
        else model_step();
        #2;
        top = (m_lvl == 0) ? 0 : m_lvl - 1;
        check("epc", epc, m_pc[top]);
        check("bd", {31'b0, bd}, {31'b0, m_bd[top]});
        check("level", {29'b0, level}, m_lvl);
        check("exl", {31'b0, exl}, {31'b0, m_lvl != 0});
        check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        check("underflow", {31'b0, underflow}, {31'b0, m_unf});
    end

    task automatic cyc(input logic ev, input logic [31:0] pc, input logic ds, input logic er,
                       input logic we, input logic [31:0] wd, input logic clr);
        @(negedge clk);
        exc_valid = ev; exc_pc = pc; exc_in_ds = ds; eret = er;
        mtc0_we = we; mtc0_data = wd; clr_flags = clr;
        @(posedge clk);
        #3;
        exc_valid = 0; exc_in_ds = 0; eret = 0; mtc0_we = 0; clr_flags = 0;
    endtask

    task automatic push(input logic [31:0] pc, input logic ds);
        cyc(1, pc, ds, 0, 0, 32'h0, 0);
    endtask

    task automatic pop();
        cyc(0, 32'h0, 0, 1, 0, 32'h0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        exc_valid = 0; exc_pc = '0; exc_in_ds = 0; eret = 0;
        mtc0_we = 0; mtc0_data = '0; clr_flags = 0;
        repeat (2) @(posedge clk);
        #3;
        check("rst_epc", epc, 32'h0);
        check("rst_level", {29'b0, level}, 32'd0);
        check("rst_flags", {29'b0, exl, overflow, underflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Nesting
        push(32'h0040_0010, 0);
        push(32'h0040_0200, 1);
        check("nest_epc", epc, 32'h0040_01FC);
        check("nest_bd", {31'b0, bd}, 32'd1);
        check("nest_level", {29'b0, level}, 32'd2);
        pop();
        check("eret1_epc", epc, 32'h0040_0010);
        check("eret1_bd", {31'b0, bd}, 32'd0);
        pop();
        check("eret2_level", {29'b0, level}, 32'd0);
        check("eret2_exl", {31'b0, exl}, 32'd0);

        // Asynchronous reset between edges
        push(32'h0000_1111, 0);
        push(32'h0000_2222, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_epc", epc, 32'h0);
        check("async_level", {29'b0, level}, 32'd0);
        check("async_exl", {31'b0, exl}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full and empty
        for (int i = 0; i < 5; i++) push(32'h1000 + 32'(i) * 32'h10, 0);
        check("full_level", {29'b0, level}, 32'd4);
        check("full_ovf", {31'b0, overflow}, 32'd1);
        check("full_epc", epc, 32'h1040);
        for (int i = 0; i < 5; i++) pop();
        check("empty_level", {29'b0, level}, 32'd0);
        check("empty_unf", {31'b0, underflow}, 32'd1);
        cyc(0, 32'h0, 0, 0, 0, 32'h0, 1);
        check("clr_flags", {30'b0, overflow, underflow}, 32'd0);

        // Simultaneous events
        push(32'h100, 0);
        cyc(1, 32'h300, 0, 1, 0, 32'h0, 0);
        check("swap_level", {29'b0, level}, 32'd1);
        check("swap_epc", epc, 32'h300);
        pop();
        cyc(1, 32'h500, 0, 1, 0, 32'h0, 0);
        check("swap0_level", {29'b0, level}, 32'd1);
        check("swap0_unf", {31'b0, underflow}, 32'd0);
        cyc(1, 32'h600, 0, 0, 1, 32'hDEAD_BEEF, 0);
        check("mtc0_lost", epc, 32'h600);
        pop();
        pop();

        // MTC0
        push(32'h10, 0);
        push(32'h24, 1);
        cyc(0, 32'h0, 0, 0, 1, 32'hBFC0_0000, 0);
        check("mtc0_epc", epc, 32'hBFC0_0000);
        check("mtc0_bd", {31'b0, bd}, 32'd1);
        check("mtc0_level", {29'b0, level}, 32'd2);
        pop();
        check("mtc0_e0", epc, 32'h10);
        pop();
        cyc(0, 32'h0, 0, 0, 1, 32'h1234, 0);
        check("mtc0_l0", epc, 32'h1234);

        // Wrap below zero
        push(32'h0, 1);
        check("wrap_epc", epc, 32'hFFFF_FFFC);
        check("wrap_bd", {31'b0, bd}, 32'd1);
        check("wrap16_epc", {16'b0, epc16}, 32'h0000_FFFC);
        check("wrap16_bd", {31'b0, bd16}, 32'd1);
        pop();

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            cyc($urandom_range(99) < 35, $urandom, $urandom_range(1), $urandom_range(99) < 35,
                $urandom_range(99) < 25, $urandom, $urandom_range(99) < 10);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/epc_stack.md
# epc_stack

Parametrised exception-PC unit for the pipelined MIPS core, replacing the single EPC register with a stack of saved return addresses so that nested exceptions can be taken and unwound with ERET. It captures the faulting PC and branch-delay status on each exception, supports MTC0 writes to the current entry, and drives the current EPC, nesting level and error flags to CP0 and the PC-select logic.

## Interface
Parameters:
- WIDTH, 32, address width of each saved PC.
- DEPTH, 4, number of stack entries (≥2).
- RESET_VAL, 0, reset value of every entry.

Ports (LW = $clog2(DEPTH+1)):
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low; the core has one clock domain.
- exc_valid  in  1  exception taken this cycle, which pushes a new entry.
- exc_pc  in  WIDTH  PC of the faulting instruction.
- exc_in_ds  in  1  the faulting instruction is in a branch delay slot.
- eret  in  1  ERET retiring, which pops the current entry.
- mtc0_we  in  1  MTC0 write to EPC.
- mtc0_data  in  WIDTH  MTC0 write data.
- clr_flags  in  1  clears the sticky overflow and underflow flags.
- epc  out  WIDTH  current entry: entry[level-1], or entry[0] when level=0.
- bd  out  1  branch-delay bit of the current entry.
- level  out  LW  nesting depth, 0..DEPTH.
- exl  out  1  level != 0.
- overflow  out  1  sticky: an exception arrived with the stack full.
- underflow  out  1  sticky: ERET arrived with the stack empty.

## Operation
- State: entry[0..DEPTH-1] (WIDTH bits each plus a bd bit), level, overflow, underflow.
- Captured value: if exc_in_ds=1, store exc_pc - 4 (mod 2^WIDTH, wraps at 0) with bd=1. Otherwise store exc_pc with bd=0.
- Priority per cycle: exc_valid, then eret, then mtc0_we. Inputs with lower priority are ignored in that cycle.
- exc_valid, eret=0:
  - If level<DEPTH, write entry[level] and increment level.
  - If level=DEPTH, overwrite entry[DEPTH-1], leave level unchanged, set overflow.
- exc_valid and eret together:
  - If level>0, overwrite entry[level-1] and leave level unchanged (pop, then push).
  - If level=0, behave as a plain push; underflow is not set.
- eret alone:
  - If level>0, decrement level; entry contents are retained.
  - If level=0, leave all state unchanged and set underflow.
- mtc0_we alone: write mtc0_data to entry[level-1], or to entry[0] when level=0. The bd bit is unchanged and level is unchanged.
- clr_flags clears overflow and underflow. If an event in the same cycle would set a flag, the set wins.
- Outputs are combinational from registered state only; no input reaches an output combinationally.

## Timing
- Reset (rst_n low, asynchronous) sets every entry to RESET_VAL with bd=0, and sets level=0 and both flags to 0. Outputs are then epc=RESET_VAL, bd=0, level=0, exl=0, overflow=0, underflow=0.
- Deassertion of rst_n is synchronised externally; the block needs no recovery cycle.
- Latency: an update sampled on edge N is visible on the outputs after edge N. A push followed by ERET on the next cycle returns the pushed value on epc during the ERET cycle.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- There is no handshake; each input is a single-cycle qualifier and is sampled every edge.

## Test plan
- Reset: drive rst_n low asynchronously between edges with level=2 → all outputs return to reset values immediately; epc=0, level=0.
- Nesting: push 0x0040_0010, push 0x0040_0200 with exc_in_ds=1, then ERET twice.
  - After the pushes: epc=0x0040_01FC, bd=1, level=2.
  - After ERET 1: epc=0x0040_0010, bd=0.
  - After ERET 2: level=0, exl=0.
- Full and empty (DEPTH=4):
  - Five pushes → level=4, overflow=1, epc = value of the 5th push.
  - Then five ERETs → level=0, underflow=1.
  - Then clr_flags → both flags 0.
- Simultaneous events:
  - level=1 (0x100), exc_valid plus eret with exc_pc=0x300 → level=1, epc=0x300.
  - level=0, same stimulus → level=1, underflow=0.
  - exc_valid plus mtc0_we → the MTC0 write is lost.
- MTC0: level=2, write 0xBFC0_0000 → epc=0xBFC0_0000, bd unchanged. After ERET, entry[0] is intact. At level=0, a write updates entry[0], which is visible on epc.
- Wrap: exc_pc=0x0000_0000 with exc_in_ds=1 → epc=0xFFFF_FFFC, bd=1. Repeat with WIDTH=16 → epc=0xFFFC.
